// File: rtl/uart_echo_fifo_if.sv
// Receiver/transmitter handshake bundle for the echo FIFO.
// master: drives rx_*, tx_ready; slave: returns rx_ack, tx_data, tx_valid.
interface uart_echo_fifo_if;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_done, rx_data, rx_err, tx_ready,
    input  rx_ack, tx_data, tx_valid
  );

  modport slave (
    input  rx_done, rx_data, rx_err, tx_ready,
    output rx_ack, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// Echo byte FIFO between UART rx and tx: drops errored bytes, queues good ones.
// Ports: clk, rst_n, bus (slave), clear_err, count, overflow, drop_cnt.
module uart_echo_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_echo_fifo_if.slave   bus,
  input  logic              clear_err,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  state_t            state;

  logic full;
  logic drop;
  logic ovf;
  logic push;
  logic pop;

  // Full is judged on the pre-edge count, so a same-edge pop
  // never frees room for a push.
  assign full = (count == FULL);
  assign drop = bus.rx_done & bus.rx_err;
  assign ovf  = bus.rx_done & ~bus.rx_err & full;
  assign push = bus.rx_done & ~bus.rx_err & ~full;
  assign pop  = (state == IDLE) & (count != '0) & bus.tx_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      count      <= '0;
      bus.rx_ack <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= 8'h00;
    end else begin
      bus.rx_ack <= bus.rx_done;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (ovf)            overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (drop) begin
        if (clear_err)              drop_cnt <= 8'h01;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end else if (clear_err) begin
        drop_cnt <= 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      bus.tx_data  <= 8'h00;
      bus.tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus.tx_data  <= mem[rd_ptr];
            bus.tx_valid <= 1'b1;
            rd_ptr       <= rd_ptr + 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          bus.tx_valid <= 1'b0;
          state        <= BUSY;
        end
        BUSY: begin
          if (bus.tx_ready) state <= IDLE;
        end
        default: begin
          bus.tx_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: queue model plus transmitter model.
// Drives rx pulses at negedges; the transmitter samples tx_valid 2ns after posedge.
module tb_uart_echo_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_err = 1'b0;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  uart_echo_fifo_if bus();

  uart_echo_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .clear_err(clear_err),
    .count(count),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] got[$];
  bit   auto_tx = 0;
  logic man_ready = 1'b0;
  logic ready_auto = 1'b1;
  int   busy_len = 20;
  int   busy_left = 0;
  logic prev_valid = 1'b0;
  int   cyc = 0;
  int   last_valid = -100;

  assign bus.tx_ready = auto_tx ? ready_auto : man_ready;

  // Transmitter model and pulse monitor.
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (bus.tx_valid) begin
      n_chk++;
      if (!bus.tx_ready || prev_valid || (cyc - last_valid) < 3) begin
        n_fail++;
        $display("FAIL tx_pulse: ready=%0b prev_valid=%0b gap=%0d, required ready=1 prev_valid=0 gap>=3",
                 bus.tx_ready, prev_valid, cyc - last_valid);
      end
      last_valid = cyc;
      got.push_back(bus.tx_data);
      if (auto_tx) begin
        ready_auto = 1'b0;
        busy_left = busy_len;
      end
    end else if (!ready_auto) begin
      if (busy_left > 0) busy_left--;
      if (busy_left == 0) ready_auto = 1'b1;
    end
    prev_valid = bus.tx_valid;
  end

  task automatic send(input logic [7:0] d, input logic e, output logic ack);
    bus.rx_done = 1'b1;
    bus.rx_data = d;
    bus.rx_err  = e;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.rx_err  = 1'b0;
    ack = bus.rx_ack;
  endtask

  task automatic wait_got(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc && got.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.rx_ack, bus.tx_valid, bus.tx_data, count, overflow, drop_cnt} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_values: ack=%0b valid=%0b data=%h count=%0d ovf=%0b drop=%0d, required all 0",
               bus.rx_ack, bus.tx_valid, bus.tx_data, count, overflow, drop_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic ack;
    got.delete();
    man_ready = 1'b1;
    send(8'hA5, 1'b0, ack);
    n_chk++;
    if ({ack, count, bus.tx_valid} !== {1'b1, 5'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_k1: ack=%0b count=%0d valid=%0b, required 1 1 0", ack, count, bus.tx_valid);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.tx_valid, bus.tx_data, count, bus.rx_ack} !== {1'b1, 8'hA5, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_k2: valid=%0b data=%h count=%0d ack=%0b, required 1 a5 0 0",
               bus.tx_valid, bus.tx_data, count, bus.rx_ack);
    end
    man_ready = 1'b0;
    repeat (2) @(negedge clk);
    man_ready = 1'b1;
    repeat (2) @(negedge clk);
    man_ready = 1'b0;
  endtask

  task automatic test_burst();
    logic ack;
    int   acks = 0;
    got.delete();
    man_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b0, ack);
      acks += int'(ack);
    end
    n_chk++;
    if (count !== 5'd5 || acks != 5) begin
      n_fail++;
      $display("FAIL burst_fill: count=%0d acks=%0d, required 5 5", count, acks);
    end
    busy_len = 20;
    auto_tx = 1;
    wait_got(5, 400);
    repeat (4) @(negedge clk);
    n_chk++;
    if (got.size() != 5 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL burst_drain: sent=%0d count=%0d, required 5 0", got.size(), count);
    end
    for (int i = 0; i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL burst_order[%0d]: got %h, required %h", i, got[i], 8'(i + 1));
      end
    end
    auto_tx = 0;
  endtask

  task automatic test_overflow();
    logic ack;
    int   acks = 0;
    got.delete();
    man_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      send(8'(i), 1'b0, ack);
      acks += int'(ack);
    end
    n_chk++;
    if (count !== 5'd16 || overflow !== 1'b1 || acks != DEPTH + 2) begin
      n_fail++;
      $display("FAIL ovf_fill: count=%0d ovf=%0b acks=%0d, required 16 1 18", count, overflow, acks);
    end
    busy_len = 2;
    auto_tx = 1;
    wait_got(DEPTH, 600);
    repeat (20) @(negedge clk);
    n_chk++;
    if (got.size() != DEPTH || count !== 5'd0) begin
      n_fail++;
      $display("FAIL ovf_drain: sent=%0d count=%0d, required 16 0", got.size(), count);
    end
    for (int i = 0; i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== 8'(i)) begin
        n_fail++;
        $display("FAIL ovf_order[%0d]: got %h, required %h", i, got[i], 8'(i));
      end
    end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%0b, required 0", overflow);
    end
    auto_tx = 0;
  endtask

  task automatic test_err_drop();
    logic ack;
    int   md = 0;
    got.delete();
    busy_len = 3;
    auto_tx = 1;
    for (int i = 0; i < 3; i++) begin
      send(8'($urandom), 1'b1, ack);
      md++;
    end
    send(8'h3C, 1'b0, ack);
    wait_got(1, 100);
    repeat (10) @(negedge clk);
    n_chk++;
    if (drop_cnt !== 8'(md) || got.size() != 1 || got[0] !== 8'h3C) begin
      n_fail++;
      $display("FAIL err_drop: drop=%0d sent=%0d, required drop=%0d only 3c", drop_cnt, got.size(), md);
    end
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 1'b1, ack);
      md = (md == 255) ? 255 : md + 1;
    end
    repeat (5) @(negedge clk);
    n_chk++;
    if (drop_cnt !== 8'(md) || got.size() != 1) begin
      n_fail++;
      $display("FAIL err_saturate: drop=%0d sent=%0d, required %0d 1", drop_cnt, got.size(), md);
    end
    clear_err = 1'b1;
    send(8'h00, 1'b1, ack);
    clear_err = 1'b0;
    n_chk++;
    if (drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL err_clear_race: drop=%0d, required 1", drop_cnt);
    end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    n_chk++;
    if (drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL err_clear: drop=%0d, required 0", drop_cnt);
    end
    auto_tx = 0;
  endtask

  task automatic test_simul();
    logic ack;
    repeat (30) @(negedge clk);
    got.delete();
    man_ready = 1'b0;
    send(8'h11, 1'b0, ack);
    send(8'h22, 1'b0, ack);
    man_ready = 1'b1;
    send(8'h33, 1'b0, ack);
    n_chk++;
    if ({count, bus.tx_valid, bus.tx_data} !== {5'd2, 1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL simul_count: count=%0d valid=%0b data=%h, required 2 1 11",
               count, bus.tx_valid, bus.tx_data);
    end
    man_ready = 1'b0;
    @(negedge clk);
    busy_len = 1;
    auto_tx = 1;
    wait_got(3, 100);
    repeat (4) @(negedge clk);
    n_chk++;
    if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL simul_order: sent=%0d count=%0d, required 11 22 33 and count 0", got.size(), count);
    end
    auto_tx = 0;
  endtask

  task automatic test_random_wrap();
    logic       ack;
    logic [7:0] mq[$];
    logic [7:0] d;
    logic       e;
    int         pushed = 0;
    int         good = 0;
    int         md = 0;
    int         acks = 0;
    int         sends = 0;
    logic       mo = 1'b0;
    got.delete();
    auto_tx = 1;
    while (good < 40) begin
      busy_len = $urandom_range(1, 6);
      e = ($urandom_range(0, 7) == 0);
      d = 8'($urandom);
      if (e) md = (md == 255) ? 255 : md + 1;
      else begin
        good++;
        if (pushed - got.size() == DEPTH) mo = 1'b1;
        else begin
          mq.push_back(d);
          pushed++;
        end
      end
      send(d, e, ack);
      sends++;
      acks += int'(ack);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    wait_got(pushed, 3000);
    repeat (10) @(negedge clk);
    n_chk++;
    if (got.size() != mq.size() || count !== 5'd0 || acks != sends) begin
      n_fail++;
      $display("FAIL rand_drain: sent=%0d count=%0d acks=%0d, required %0d 0 %0d",
               got.size(), count, acks, mq.size(), sends);
    end
    for (int i = 0; i < mq.size() && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== mq[i]) begin
        n_fail++;
        $display("FAIL rand_order[%0d]: got %h, required %h", i, got[i], mq[i]);
      end
    end
    n_chk++;
    if (drop_cnt !== 8'(md) || overflow !== mo) begin
      n_fail++;
      $display("FAIL rand_status: drop=%0d ovf=%0b, required %0d %0b", drop_cnt, overflow, md, mo);
    end
    auto_tx = 0;
  endtask

  task automatic test_reset_mid();
    logic ack;
    repeat (30) @(negedge clk);
    got.delete();
    busy_len = 30;
    auto_tx = 1;
    for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i), 1'b0, ack);
    repeat (3) @(negedge clk);
    n_chk++;
    if (count !== 5'd4 || got.size() != 1) begin
      n_fail++;
      $display("FAIL mid_setup: count=%0d sent=%0d, required 4 1", count, got.size());
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({count, bus.tx_valid} !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_async: count=%0d valid=%0b, required 0 0", count, bus.tx_valid);
    end
    @(negedge clk);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.rx_ack, bus.tx_valid, bus.tx_data, count, overflow, drop_cnt} !== 24'h0) begin
      n_fail++;
      $display("FAIL mid_reset: ack=%0b valid=%0b data=%h count=%0d ovf=%0b drop=%0d, required all 0",
               bus.rx_ack, bus.tx_valid, bus.tx_data, count, overflow, drop_cnt);
    end
    rst_n = 1'b1;
    auto_tx = 0;
    man_ready = 1'b1;
    repeat (20) @(negedge clk);
    n_chk++;
    if (got.size() != 1) begin
      n_fail++;
      $display("FAIL mid_quiet: sent=%0d, required 1", got.size());
    end
    send(8'h5A, 1'b0, ack);
    wait_got(2, 20);
    n_chk++;
    if (got.size() != 2 || got[got.size()-1] !== 8'h5A) begin
      n_fail++;
      $display("FAIL mid_resume: sent=%0d last=%h, required 2 5a", got.size(), got[got.size()-1]);
    end
    man_ready = 1'b0;
  endtask

  initial begin
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_err  = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_err_drop();
    test_simul();
    test_random_wrap();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, required completion before 2ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Byte buffer and transmit scheduler between the UART receiver and transmitter in the loopback path. It accepts each received byte on the receiver's one-cycle done pulse and returns the acknowledge that releases the receiver's HOLD state. It discards errored bytes, queues good ones in a power-of-two FIFO, and replays them to the transmitter through a valid/ready handshake. Back-to-back frames from the host are therefore echoed without loss while the transmitter is busy.

## Interface
- DEPTH, 16, FIFO entries; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- clk  in  1  system clock (27 MHz on board).
- rst_n  in  1  reset, asynchronous, active-low.
- rx_done  in  1  one-cycle pulse; rx_data/rx_err valid in that cycle.
- rx_data  in  8  received byte.
- rx_err  in  1  parity OR framing error for the byte flagged by rx_done.
- rx_ack  out  1  one-cycle acknowledge to receiver, cycle after every rx_done.
- tx_data  out  8  byte to transmit; registered, stable from launch until next launch.
- tx_valid  out  1  one-cycle start pulse to transmitter.
- tx_ready  in  1  transmitter idle; drops within 1 cycle after sampling tx_valid.
- clear_err  in  1  synchronous clear of overflow and drop_cnt.
- count  out  ADDR_W+1  bytes currently stored, 0..DEPTH.
- overflow  out  1  sticky: a good byte arrived while full.
- drop_cnt  out  8  errored bytes discarded; saturates at 255.

## Operation
- Storage: DEPTH x 8 memory, wr_ptr/rd_ptr of ADDR_W bits wrapping modulo DEPTH, count register ADDR_W+1 bits. Memory contents are not reset.
- Push, decided in the rx_done cycle:
  - rx_err=1: byte discarded; drop_cnt += 1 unless already 255.
  - rx_err=0 and count==DEPTH: byte discarded; overflow <= 1.
  - otherwise: mem[wr_ptr] <= rx_data; wr_ptr++.
- rx_ack <= rx_done on every clock, whether the byte was stored or dropped.
- TX FSM, three states:
  - IDLE: if count!=0 and tx_ready=1, then tx_data <= mem[rd_ptr], rd_ptr++, tx_valid <= 1, go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_valid <= 0; go to BUSY unconditionally.
  - BUSY: stay while tx_ready=0; go to IDLE on tx_ready=1.
- count update: +1 on push only, -1 on pop only, unchanged when push and pop happen on the same edge.
- A push into an empty FIFO and a pop cannot coincide, because pop requires count!=0 before the edge.
- A push while full is blocked even if a pop occurs on the same edge. Full is judged on the pre-edge count.
- clear_err: overflow <= 0 and drop_cnt <= 0, unless a new overflow or drop event occurs on the same edge. The event wins: overflow=1, or drop_cnt=1.
- Unknown FSM encodings return to IDLE.

## Timing
- Reset values: rx_ack=0, tx_valid=0, tx_data=8'h00, count=0, overflow=0, drop_cnt=0, FSM=IDLE, wr_ptr=rd_ptr=0.
- Reset asserted mid-operation: queued bytes are lost. tx_valid drops immediately, asynchronously. A transmission already in flight in the transmitter is not aborted by this block.
- Latency to TX: rx_done in cycle k (FIFO empty, FSM IDLE, tx_ready=1) gives count=1 and rx_ack=1 in cycle k+1, then tx_valid=1 in cycle k+2 with tx_data equal to the byte.
- tx_valid is exactly one cycle wide. At most one tx_valid per tx_ready low-then-high cycle.
- Minimum spacing between consecutive tx_valid pulses is 3 cycles: LAUNCH, one BUSY cycle, IDLE.
- count, overflow and drop_cnt are registered and update on the edge that ends the event cycle.

## Test plan
- Single byte: rx_done with rx_data=8'hA5, rx_err=0, transmitter idle → rx_ack high 1 cycle later; tx_valid high 2 cycles after rx_done with tx_data=8'hA5; count returns to 0.
- Burst ordering: hold tx_ready=0, push 8'h01..8'h05 → count=5. Release tx_ready and model a transmitter busy for 20 cycles per byte → tx_data sequence 01,02,03,04,05, one tx_valid per byte, count ends at 0.
- Full/overflow: hold tx_ready=0, push DEPTH+2 bytes (00..11 hex) → count saturates at 16, overflow=1. After drain, only bytes 00..0F are transmitted. Every rx_done still produces an rx_ack.
- Error drop: 3 rx_done pulses with rx_err=1 and 1 with rx_err=0 (8'h3C) → drop_cnt=3, only 8'h3C is transmitted. 300 error pulses → drop_cnt=255. clear_err → 0.
- Simultaneous push/pop: count=2 and FSM launching in the same cycle as a good rx_done → count stays 2; all bytes emerge in order; wrap-around checked by pushing 40 bytes through with DEPTH=16.
- Reset mid-operation: 4 bytes queued, FSM in BUSY, assert rst_n=0 for 3 cycles → all outputs at reset values, count=0. After release, no tx_valid until a new rx_done arrives.
